ddr_mem_responder: RTL and testbench



---
 rtl/ddr_mem_responder.sv | 199 +++++++++++++++++++
 tb/tb_ddr_mem_responder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_mem_responder.sv
// ddr_mem_responder: SDRAM command decoder, per-bank row tracker and
// burst engine that answers controller reads/writes from a local array.
module ddr_mem_responder #(
    parameter int DQ_W  = 32,
    parameter int ROW_W = 4,
    parameter int COL_W = 6
) (
    input  logic            clk,
    input  logic            rst2,
    input  logic            sdc_cs_n,
    input  logic            sdc_ras_n,
    input  logic            sdc_cas_n,
    input  logic            sdc_we_n,
    input  logic [1:0]      sdc_ba,
    input  logic [11:0]     sdc_addr,
    input  logic [DQ_W-1:0] dq_in,
    output logic [DQ_W-1:0] dq_out,
    output logic            dq_oe,
    output logic            dqs_oe,
    output logic            rd_valid,
    output logic            cmd_err
);
    localparam int AW    = 2 + ROW_W + COL_W;
    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST} state_t;

    logic [DQ_W-1:0]  mem [DEPTH];

    state_t           st_q, st_d;
    logic [2:0]       k_q, k_d;
    logic [1:0]       bba_q, bba_d;
    logic [ROW_W-1:0] brow_q, brow_d;
    logic [COL_W-1:0] bcol_q, bcol_d;
    logic             bcl2_q, bcl2_d;

    logic [3:0]       open_q;
    logic [ROW_W-1:0] row_q [4];
    logic [1:0]       bl_q;
    logic             il_q;
    logic             cl2_q;
    logic             err_q;

    logic             s1_v_q, s1_v_d;
    logic [AW-1:0]    s1_a_q;
    logic [DQ_W-1:0]  dq_out_q;
    logic             rd_valid_q;
    logic             dqs_oe_q;

    logic [2:0]       cmd;
    logic             is_act, is_rd, is_wr, is_pre, is_lmr;
    logic             rw_ok, rw_bad, lmr_ok, set_err;
    logic [2:0]       bl_mask;
    logic [COL_W-1:0] k_c, mask_c, beat_col;
    logic [AW-1:0]    beat_addr;
    logic             fsm_src, src_v, src_v_nxt;
    logic [AW-1:0]    src_a;
    logic             unused_addr;

    assign cmd    = {sdc_ras_n, sdc_cas_n, sdc_we_n};
    assign is_act = !sdc_cs_n && (cmd == 3'b011);
    assign is_rd  = !sdc_cs_n && (cmd == 3'b101);
    assign is_wr  = !sdc_cs_n && (cmd == 3'b100);
    assign is_pre = !sdc_cs_n && (cmd == 3'b010);
    assign is_lmr = !sdc_cs_n && (cmd == 3'b000);

    assign rw_ok   = (is_rd || is_wr) && open_q[sdc_ba];
    assign rw_bad  = (is_rd || is_wr) && !open_q[sdc_ba];
    assign lmr_ok  = is_lmr && (st_q == IDLE) && !s1_v_q
                     && (open_q == 4'd0);
    assign set_err = rw_bad || (is_lmr && !lmr_ok)
                     || (lmr_ok && sdc_addr[2]);

    assign unused_addr = ^{sdc_addr[11], sdc_addr[9:7]};

    // Burst length code to the column wrap mask
    always_comb begin
        unique case (bl_q)
            2'd0:    bl_mask = 3'd0;
            2'd1:    bl_mask = 3'd1;
            2'd2:    bl_mask = 3'd3;
            default: bl_mask = 3'd7;
        endcase
    end

    assign k_c      = COL_W'(k_q);
    assign mask_c   = COL_W'(bl_mask);
    assign beat_col = il_q ? (bcol_q ^ k_c)
                    : ((bcol_q & ~mask_c) | ((bcol_q + k_c) & mask_c));
    assign beat_addr = {bba_q, brow_q, beat_col};

    // CL2 reads feed the array straight from the burst generator;
    // CL3 reads pass through one extra address stage first.
    assign fsm_src = (st_q == RD_BURST) && bcl2_q;
    assign src_v   = fsm_src || s1_v_q;
    assign src_a   = fsm_src ? beat_addr : s1_a_q;
    assign s1_v_d  = (st_q == RD_BURST) && !bcl2_q;
    assign src_v_nxt = ((st_d == RD_BURST) && bcl2_d) || s1_v_d;

    // Burst next state: advance, finish, precharge abort or restart
    always_comb begin
        st_d   = st_q;
        k_d    = k_q;
        bba_d  = bba_q;
        brow_d = brow_q;
        bcol_d = bcol_q;
        bcl2_d = bcl2_q;
        if (st_q != IDLE) begin
            if (k_q == bl_mask) st_d = IDLE;
            else                k_d  = k_q + 3'd1;
        end
        if (is_pre && (st_q != IDLE)
            && (sdc_addr[10] || (sdc_ba == bba_q))) begin
            st_d = IDLE;
        end
        if (rw_ok) begin
            st_d   = is_rd ? RD_BURST : WR_BURST;
            k_d    = 3'd0;
            bba_d  = sdc_ba;
            brow_d = row_q[sdc_ba];
            bcol_d = sdc_addr[COL_W-1:0];
            if (is_rd) bcl2_d = cl2_q;
        end
    end

    // Burst FSM registers
    always_ff @(posedge clk or negedge rst2) begin
        if (!rst2) begin
            st_q   <= IDLE;
            k_q    <= 3'd0;
            bba_q  <= 2'd0;
            brow_q <= '0;
            bcol_q <= '0;
            bcl2_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            k_q    <= k_d;
            bba_q  <= bba_d;
            brow_q <= brow_d;
            bcol_q <= bcol_d;
            bcl2_q <= bcl2_d;
        end
    end

    // Bank/row bookkeeping, mode register and sticky error flag
    always_ff @(posedge clk or negedge rst2) begin
        if (!rst2) begin
            open_q <= 4'd0;
            for (int i = 0; i < 4; i++) row_q[i] <= '0;
            bl_q   <= 2'd2;
            il_q   <= 1'b0;
            cl2_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            if (is_act) begin
                open_q[sdc_ba] <= 1'b1;
                row_q[sdc_ba]  <= sdc_addr[ROW_W-1:0];
            end
            if (is_pre) begin
                if (sdc_addr[10]) open_q <= 4'd0;
                else              open_q[sdc_ba] <= 1'b0;
            end
            if (lmr_ok) begin
                bl_q  <= sdc_addr[2] ? 2'd3 : sdc_addr[1:0];
                il_q  <= sdc_addr[3];
                cl2_q <= (sdc_addr[6:4] == 3'b010);
            end
            if (set_err) err_q <= 1'b1;
        end
    end

    // Write beats land in the array; not cleared by reset
    always_ff @(posedge clk) begin
        if (st_q == WR_BURST) mem[beat_addr] <= dq_in;
    end

    // Read pipeline, registered array read and output enables
    always_ff @(posedge clk or negedge rst2) begin
        if (!rst2) begin
            s1_v_q     <= 1'b0;
            s1_a_q     <= '0;
            rd_valid_q <= 1'b0;
            dqs_oe_q   <= 1'b0;
            dq_out_q   <= '0;
        end else begin
            s1_v_q     <= s1_v_d;
            s1_a_q     <= beat_addr;
            rd_valid_q <= src_v;
            dqs_oe_q   <= src_v || src_v_nxt;
            if (src_v) dq_out_q <= mem[src_a];
        end
    end

    assign dq_out   = dq_out_q;
    assign rd_valid = rd_valid_q;
    assign dq_oe    = rd_valid_q;
    assign dqs_oe   = dqs_oe_q;
    assign cmd_err  = err_q;
endmodule

// File: tb/tb_ddr_mem_responder.sv
// tb_ddr_mem_responder: directed command sequences with hand-computed
// read data and enable timing for ddr_mem_responder.
module tb_ddr_mem_responder;
    localparam logic [2:0] NOP = 3'b111;
    localparam logic [2:0] ACT = 3'b011;
    localparam logic [2:0] RD  = 3'b101;
    localparam logic [2:0] WR  = 3'b100;
    localparam logic [2:0] PRE = 3'b010;
    localparam logic [2:0] LMR = 3'b000;

    localparam logic [31:0] ABASE = 32'hA000_0000;
    localparam logic [31:0] OBASE = 32'hB000_0000;
    localparam logic [31:0] NBASE = 32'hC000_0000;

    logic        clk = 1'b0;
    logic        rst2;
    logic        cs_n, ras_n, cas_n, we_n;
    logic [1:0]  ba;
    logic [11:0] addr;
    logic [31:0] dq_in;
    logic [31:0] dq_out;
    logic        dq_oe, dqs_oe, rd_valid, cmd_err;

    int total  = 0;
    int passed = 0;
    int fails  = 0;
    logic [31:0] exp_w [8];

    ddr_mem_responder dut (
        .clk       (clk),
        .rst2      (rst2),
        .sdc_cs_n  (cs_n),
        .sdc_ras_n (ras_n),
        .sdc_cas_n (cas_n),
        .sdc_we_n  (we_n),
        .sdc_ba    (ba),
        .sdc_addr  (addr),
        .dq_in     (dq_in),
        .dq_out    (dq_out),
        .dq_oe     (dq_oe),
        .dqs_oe    (dqs_oe),
        .rd_valid  (rd_valid),
        .cmd_err   (cmd_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] c, input logic [1:0] b,
                         input logic [11:0] a);
        {ras_n, cas_n, we_n} = c;
        ba   = b;
        addr = a;
    endtask

    task automatic cmd(input logic [2:0] c, input logic [1:0] b,
                       input logic [11:0] a);
        drive(c, b, a);
        tick();
        drive(NOP, 2'd0, 12'd0);
    endtask

    task automatic wr_burst(input logic [1:0] b, input logic [11:0] col,
                            input logic [31:0] base, input int n);
        cmd(WR, b, col);
        for (int i = 0; i < n; i++) begin
            dq_in = base + 32'(i);
            tick();
        end
    endtask

    // Sample i is taken just after the i-th edge following the READ edge.
    task automatic expect_burst(input string tag, input int first,
                                input int nw, input int cycles);
        logic ev, ed;
        for (int i = 0; i < cycles; i++) begin
            ev = (i >= first) && (i < first + nw);
            ed = (i >= first - 1) && (i < first + nw);
            chk($sformatf("%s rd_valid[%0d]", tag, i), rd_valid, ev);
            chk($sformatf("%s dq_oe[%0d]", tag, i), dq_oe, ev);
            chk($sformatf("%s dqs_oe[%0d]", tag, i), dqs_oe, ed);
            if (ev)
                chk($sformatf("%s dq_out[%0d]", tag, i), dq_out,
                    exp_w[i-first]);
            tick();
        end
    endtask

    initial begin
        logic ev, ed;
        logic [31:0] ew;
        rst2  = 1'b0;
        cs_n  = 1'b0;
        dq_in = 32'd0;
        drive(NOP, 2'd0, 12'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst dq_out", dq_out, 32'd0);
        chk("rst dq_oe", dq_oe, 1'b0);
        chk("rst dqs_oe", dqs_oe, 1'b0);
        chk("rst rd_valid", rd_valid, 1'b0);
        chk("rst cmd_err", cmd_err, 1'b0);
        rst2 = 1'b1;
        tick();

        // CL2 BL4 sequential write then wrapped read
        cmd(LMR, 2'd0, 12'h022);
        cmd(ACT, 2'd0, 12'd1);
        wr_burst(2'd0, 12'd4, ABASE, 4);
        chk("t1 dqs_oe idle", dqs_oe, 1'b0);
        cmd(RD, 2'd0, 12'd6);
        exp_w = '{ABASE + 2, ABASE + 3, ABASE, ABASE + 1, 0, 0, 0, 0};
        expect_burst("t1", 1, 4, 6);
        chk("t1 dq_out hold", dq_out, ABASE + 1);

        // CL3 BL8 interleaved read of prefilled column pattern
        cmd(PRE, 2'd0, 12'h400);
        cmd(LMR, 2'd0, 12'h03B);
        cmd(ACT, 2'd1, 12'd2);
        wr_burst(2'd1, 12'd0, 32'd0, 8);
        wr_burst(2'd1, 12'd16, 32'd16, 8);
        cmd(RD, 2'd1, 12'd5);
        exp_w = '{32'd5, 32'd4, 32'd7, 32'd6, 32'd1, 32'd0, 32'd3, 32'd2};
        expect_burst("t2", 2, 8, 11);

        // Deselected command ignored; READ to closed bank flags error
        cs_n = 1'b1;
        drive(RD, 2'd2, 12'd0);
        tick();
        cs_n = 1'b0;
        drive(NOP, 2'd0, 12'd0);
        chk("t3 cs_n high no err", cmd_err, 1'b0);
        cmd(RD, 2'd2, 12'd0);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t3 rd_valid[%0d]", i), rd_valid, 1'b0);
            chk($sformatf("t3 dq_oe[%0d]", i), dq_oe, 1'b0);
            chk($sformatf("t3 cmd_err[%0d]", i), cmd_err, 1'b1);
            tick();
        end
        cmd(ACT, 2'd2, 12'd3);
        cmd(PRE, 2'd2, 12'd0);
        chk("t3 cmd_err sticky", cmd_err, 1'b1);

        // Read truncated by a second read: contiguous output
        for (int i = 0; i < 14; i++) begin
            if (i == 0)      drive(RD, 2'd1, 12'd0);
            else if (i == 2) drive(RD, 2'd1, 12'd16);
            else             drive(NOP, 2'd0, 12'd0);
            tick();
            ev = (i >= 2) && (i <= 11);
            ed = (i >= 1) && (i <= 11);
            ew = (i == 3) ? 32'd1 : (i == 2) ? 32'd0 : 32'(16 + i - 4);
            chk($sformatf("t4 rd_valid[%0d]", i), rd_valid, ev);
            chk($sformatf("t4 dqs_oe[%0d]", i), dqs_oe, ed);
            chk($sformatf("t4 dq_oe[%0d]", i), dq_oe, ev);
            if (ev) chk($sformatf("t4 dq_out[%0d]", i), dq_out, ew);
        end
        drive(NOP, 2'd0, 12'd0);

        // Write truncated by a read: only first two beats stored
        cmd(PRE, 2'd0, 12'h400);
        cmd(LMR, 2'd0, 12'h032);
        cmd(ACT, 2'd3, 12'd5);
        wr_burst(2'd3, 12'd8, OBASE, 4);
        exp_w = '{NBASE, NBASE + 1, OBASE + 2, OBASE + 3, 0, 0, 0, 0};
        for (int i = 0; i < 10; i++) begin
            if (i == 0)      drive(WR, 2'd3, 12'd8);
            else if (i == 2) drive(RD, 2'd3, 12'd8);
            else             drive(NOP, 2'd0, 12'd0);
            if (i >= 1) dq_in = NBASE + 32'(i - 1);
            tick();
            ev = (i >= 4) && (i <= 7);
            ed = (i >= 3) && (i <= 7);
            chk($sformatf("t5 rd_valid[%0d]", i), rd_valid, ev);
            chk($sformatf("t5 dqs_oe[%0d]", i), dqs_oe, ed);
            if (ev) chk($sformatf("t5 dq_out[%0d]", i), dq_out, exp_w[i-4]);
        end
        drive(NOP, 2'd0, 12'd0);

        // Asynchronous reset in the middle of a CL2 BL8 read
        cmd(PRE, 2'd0, 12'h400);
        cmd(LMR, 2'd0, 12'h023);
        cmd(ACT, 2'd3, 12'd5);
        cmd(RD, 2'd3, 12'd8);
        tick();
        chk("t6 pre-reset rd_valid", rd_valid, 1'b1);
        chk("t6 pre-reset dq_out", dq_out, NBASE);
        #2 rst2 = 1'b0;
        #1;
        chk("t6 async rd_valid", rd_valid, 1'b0);
        chk("t6 async dq_oe", dq_oe, 1'b0);
        chk("t6 async dqs_oe", dqs_oe, 1'b0);
        chk("t6 async dq_out", dq_out, 32'd0);
        #2 rst2 = 1'b1;
        cmd(ACT, 2'd3, 12'd5);
        cmd(RD, 2'd3, 12'd9);
        exp_w = '{NBASE + 1, OBASE + 2, OBASE + 3, NBASE, 0, 0, 0, 0};
        expect_burst("t6 default", 2, 4, 7);
        chk("t6 cmd_err clear", cmd_err, 1'b0);
        cmd(LMR, 2'd0, 12'h023);
        chk("t6 lmr bank open err", cmd_err, 1'b1);
        cmd(RD, 2'd3, 12'd9);
        expect_burst("t6 mode kept", 2, 4, 7);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
